// File: rtl/priv_seq_pkg.sv
// Shared types and constants for the privileged-mode sequencer and its RegBank command encoding.
package priv_seq_pkg;

  typedef enum logic [2:0] {
    USER,
    ENTER,
    CAUSE,
    VECTOR,
    KERNEL,
    EXIT
  } priv_state_t;

  // RegBank control codes
  localparam logic [2:0] CTRL_ALU   = 3'd1;
  localparam logic [2:0] CTRL_MEM   = 3'd3;
  localparam logic [2:0] CTRL_ENTER = 3'd4;
  localparam logic [2:0] CTRL_EXIT  = 3'd5;
  localparam logic [2:0] CTRL_CPXR  = 3'd6;

  localparam logic [3:0] PC_REG = 4'd15;
  localparam logic [3:0] SP_REG = 4'd14;

  // States that own the commit slot and freeze fetch/decode
  function automatic logic is_stall_state(input priv_state_t s);
    return (s == ENTER) || (s == CAUSE) || (s == VECTOR) || (s == EXIT);
  endfunction

endpackage

// File: rtl/priv_mode_sequencer_if.sv
// Decoder/RegBank-side signal bundle of the privileged-mode sequencer.
interface priv_mode_sequencer_if #(
  parameter int NUM_IRQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int SPECREG_LENGTH = 4
);
  logic                      slow_tick;
  logic                      core_boundary;
  logic [NUM_IRQ-1:0]        irq_req;
  logic [NUM_IRQ-1:0]        irq_mask;
  logic                      swi_req;
  logic                      ret_req;
  logic [2:0]                core_control;
  logic [3:0]                core_dest;
  logic                      core_branch;
  logic [2:0]                bank_control;
  logic [3:0]                bank_dest;
  logic                      bank_branch;
  logic                      alu_override;
  logic [ADDR_WIDTH-1:0]     vector_addr;
  logic [SPECREG_LENGTH-1:0] special_register;
  logic                      stall;
  logic                      in_kernel;
  logic [NUM_IRQ-1:0]        irq_ack;
  logic                      swi_ack;

  // master: core/decoder side; slave: the sequencer
  modport master (
    output slow_tick, core_boundary, irq_req, irq_mask, swi_req, ret_req,
           core_control, core_dest, core_branch,
    input  bank_control, bank_dest, bank_branch, alu_override, vector_addr,
           special_register, stall, in_kernel, irq_ack, swi_ack
  );

  modport slave (
    input  slow_tick, core_boundary, irq_req, irq_mask, swi_req, ret_req,
           core_control, core_dest, core_branch,
    output bank_control, bank_dest, bank_branch, alu_override, vector_addr,
           special_register, stall, in_kernel, irq_ack, swi_ack
  );
endinterface

// File: rtl/irq_priority_encoder.sv
// Picks the winning request: SWI is cause 0, otherwise the lowest unmasked IRQ i is cause i+1.
module irq_priority_encoder #(
  parameter int NUM_IRQ     = 4,
  parameter int CAUSE_WIDTH = 4
) (
  input  logic [NUM_IRQ-1:0]     irq_active,
  input  logic                   swi_req,
  output logic                   valid,
  output logic [CAUSE_WIDTH-1:0] cause
);

  logic [NUM_IRQ-1:0]     winner;
  logic                   any_irq;
  logic [CAUSE_WIDTH-1:0] irq_cause;

  // winner is one-hot on the lowest active line
  always_comb begin
    any_irq = 1'b0;
    winner  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      winner[i] = irq_active[i] & ~any_irq;
      any_irq   = any_irq | irq_active[i];
    end
  end

  always_comb begin
    irq_cause = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (winner[i]) irq_cause = CAUSE_WIDTH'(i + 1);
    end
  end

  assign valid = swi_req | any_irq;
  assign cause = swi_req ? '0 : irq_cause;

endmodule

// File: rtl/priv_mode_sequencer.sv
// Sequences RegBank kernel entry/exit commits for IRQ/SWI, overriding the decoder's bank inputs.
// Optional macro PRIV_CAUSE_EN adds a CAUSE commit that writes the cause code into CAUSE_REG.
module priv_mode_sequencer
  import priv_seq_pkg::*;
#(
  parameter int NUM_IRQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int VECTOR_BASE    = 2,
  parameter int VECTOR_STRIDE  = 2,
  parameter int SPECREG_LENGTH = 4,
  parameter int CAUSE_REG      = 12
) (
  input logic                  fast_clock,
  input logic                  reset,
  priv_mode_sequencer_if.slave bus
);

  // The cause write must never land on PC or SP, and every cause must fit the code width
  if (CAUSE_REG < 0 || CAUSE_REG > 15 || CAUSE_REG == int'(PC_REG) ||
      CAUSE_REG == int'(SP_REG) || NUM_IRQ >= (1 << SPECREG_LENGTH)) begin : g_bad_config
    $error("priv_mode_sequencer: invalid CAUSE_REG or NUM_IRQ");
  end

  priv_state_t               state_reg, state_next;
  logic [SPECREG_LENGTH-1:0] cause_reg, cause_next;
  logic [NUM_IRQ-1:0]        irq_active;
  logic                      req_valid;
  logic [SPECREG_LENGTH-1:0] req_cause;
  logic                      ack_fire;

  assign irq_active = bus.irq_req & ~bus.irq_mask;

  irq_priority_encoder #(
    .NUM_IRQ    (NUM_IRQ),
    .CAUSE_WIDTH(SPECREG_LENGTH)
  ) u_encoder (
    .irq_active(irq_active),
    .swi_req   (bus.swi_req),
    .valid     (req_valid),
    .cause     (req_cause)
  );

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state_reg <= USER;
      cause_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    if (bus.slow_tick) begin
      case (state_reg)
        USER: begin
          // Cause is frozen here so later request/mask changes cannot redirect the entry
          if (bus.core_boundary && req_valid) begin
            state_next = ENTER;
            cause_next = req_cause;
          end
        end
`ifdef PRIV_CAUSE_EN
        ENTER:  state_next = CAUSE;
        CAUSE:  state_next = VECTOR;
`else
        ENTER:  state_next = VECTOR;
`endif
        VECTOR: state_next = KERNEL;
        KERNEL: if (bus.core_boundary && bus.ret_req) state_next = EXIT;
        EXIT:   state_next = USER;
        default: state_next = USER;
      endcase
    end
  end

  always_comb begin
    bus.bank_control = bus.core_control;
    bus.bank_dest    = bus.core_dest;
    bus.bank_branch  = bus.core_branch;
    bus.alu_override = 1'b0;
    case (state_reg)
      ENTER: begin
        bus.bank_control = CTRL_ENTER;
        bus.bank_branch  = 1'b0;
      end
`ifdef PRIV_CAUSE_EN
      CAUSE: begin
        bus.bank_control = CTRL_CPXR;
        bus.bank_dest    = 4'(CAUSE_REG);
        bus.bank_branch  = 1'b0;
      end
`endif
      VECTOR: begin
        // PC-only write of vector_addr through the ALU result path
        bus.bank_control = CTRL_ALU;
        bus.bank_dest    = PC_REG;
        bus.bank_branch  = 1'b1;
        bus.alu_override = 1'b1;
      end
      EXIT: begin
        bus.bank_control = CTRL_EXIT;
        bus.bank_branch  = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.stall     = is_stall_state(state_reg);
  assign bus.in_kernel = (state_reg == KERNEL) || (state_reg == EXIT);

  assign bus.vector_addr = (state_reg == USER) ? '0 :
                           ADDR_WIDTH'(VECTOR_BASE) +
                           ADDR_WIDTH'(cause_reg) * ADDR_WIDTH'(VECTOR_STRIDE);

`ifdef PRIV_CAUSE_EN
  assign bus.special_register = cause_reg;
`else
  assign bus.special_register = '0;
`endif

  assign ack_fire    = (state_reg == ENTER) && bus.slow_tick;
  assign bus.swi_ack = ack_fire && (cause_reg == '0);

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq_ack
    assign bus.irq_ack[gi] = ack_fire && (cause_reg == SPECREG_LENGTH'(gi + 1));
  end

endmodule

// File: tb/tb_priv_mode_sequencer.sv
// Scoreboard bench: each commit pushes its expected RegBank response; a monitor checks every slow_tick.
module tb_priv_mode_sequencer;

  typedef struct {
    logic [2:0]  ctrl;
    logic [3:0]  dest;
    logic        br;
    logic        alu;
    logic        stall;
    logic        ink;
    logic [3:0]  ack;
    logic        swi;
    logic [31:0] va;
    bit          chk_dest;
    bit          chk_br;
    bit          chk_va;
    int          id;
  } exp_t;

  logic fast_clock = 1'b0;
  logic reset      = 1'b1;
  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   commit_id = 0;

  always #5 fast_clock = ~fast_clock;

  priv_mode_sequencer_if #(.NUM_IRQ(4), .ADDR_WIDTH(32), .SPECREG_LENGTH(4)) bus ();

  priv_mode_sequencer #(
    .NUM_IRQ(4), .ADDR_WIDTH(32), .VECTOR_BASE(2), .VECTOR_STRIDE(2),
    .SPECREG_LENGTH(4), .CAUSE_REG(12)
  ) dut (
    .fast_clock(fast_clock),
    .reset     (reset),
    .bus       (bus)
  );

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (commit %0d): got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] c, input logic [3:0] d, input logic b,
                              input logic a, input logic st, input logic ik,
                              input logic [3:0] ack, input logic sw, input logic [31:0] va,
                              input bit cd, input bit cb, input bit cv);
    exp_t e;
    e.ctrl = c; e.dest = d; e.br = b; e.alu = a; e.stall = st; e.ink = ik;
    e.ack = ack; e.swi = sw; e.va = va; e.chk_dest = cd; e.chk_br = cb; e.chk_va = cv;
    e.id = 0;
    return e;
  endfunction

  function automatic exp_t exp_pass(input logic [2:0] c, input logic [3:0] d,
                                    input logic b, input logic ik);
    return mk(c, d, b, 1'b0, 1'b0, ik, 4'b0000, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic exp_t exp_enter(input logic [3:0] ack, input logic sw);
    return mk(3'd4, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ack, sw, 32'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t exp_cause();
    return mk(3'd6, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic exp_t exp_vector(input logic [31:0] va);
    return mk(3'd1, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, va, 1'b1, 1'b1, 1'b1);
  endfunction

  function automatic exp_t exp_exit();
    return mk(3'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  // One commit slot: slow_tick high for one fast_clock cycle, then one idle cycle
  task automatic tick(input logic bnd, input logic ret, input logic [2:0] c,
                      input logic [3:0] d, input logic b, input exp_t e);
    @(posedge fast_clock); #1;
    bus.core_boundary = bnd;
    bus.ret_req       = ret;
    bus.core_control  = c;
    bus.core_dest     = d;
    bus.core_branch   = b;
    e.id = commit_id;
    commit_id++;
    sb.push_back(e);
    bus.slow_tick = 1'b1;
    @(posedge fast_clock); #1;
    bus.slow_tick     = 1'b0;
    bus.core_boundary = 1'b0;
    bus.ret_req       = 1'b0;
  endtask

  task automatic enter_seq(input logic [3:0] ack, input logic sw, input logic [31:0] va);
    tick(1'b0, 1'b0, 3'd2, 4'd3, 1'b0, exp_enter(ack, sw));
`ifdef PRIV_CAUSE_EN
    tick(1'b0, 1'b0, 3'd2, 4'd3, 1'b0, exp_cause());
`endif
    tick(1'b0, 1'b0, 3'd2, 4'd3, 1'b0, exp_vector(va));
  endtask

  task automatic exit_seq();
    tick(1'b1, 1'b1, 3'd1, 4'd15, 1'b1, exp_pass(3'd1, 4'd15, 1'b1, 1'b1));
    tick(1'b0, 1'b0, 3'd2, 4'd3, 1'b0, exp_exit());
  endtask

  always @(negedge fast_clock) begin
    exp_t e;
    if (!reset && bus.slow_tick) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: commit seen with no expected entry");
      end else begin
        e = sb.pop_front();
        $display("commit %0d: ctrl=%0d dest=%0d br=%0b alu=%0b stall=%0b kern=%0b ack=%b swi=%0b va=%0h",
                 e.id, bus.bank_control, bus.bank_dest, bus.bank_branch, bus.alu_override,
                 bus.stall, bus.in_kernel, bus.irq_ack, bus.swi_ack, bus.vector_addr);
        check("bank_control", e.id, 32'(bus.bank_control), 32'(e.ctrl));
        if (e.chk_dest) check("bank_dest", e.id, 32'(bus.bank_dest), 32'(e.dest));
        if (e.chk_br) check("bank_branch", e.id, 32'(bus.bank_branch), 32'(e.br));
        check("alu_override", e.id, 32'(bus.alu_override), 32'(e.alu));
        check("stall", e.id, 32'(bus.stall), 32'(e.stall));
        check("in_kernel", e.id, 32'(bus.in_kernel), 32'(e.ink));
        check("irq_ack", e.id, 32'(bus.irq_ack), 32'(e.ack));
        check("swi_ack", e.id, 32'(bus.swi_ack), 32'(e.swi));
        if (e.chk_va) check("vector_addr", e.id, bus.vector_addr, e.va);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.slow_tick = 1'b0; bus.core_boundary = 1'b0; bus.ret_req = 1'b0;
    bus.swi_req = 1'b0; bus.irq_req = 4'b0000; bus.irq_mask = 4'b0000;
    bus.core_control = 3'd3; bus.core_dest = 4'd9; bus.core_branch = 1'b1;
    repeat (2) @(posedge fast_clock);
    @(negedge fast_clock);
    check("reset_bank_control", -1, 32'(bus.bank_control), 32'd3);
    check("reset_bank_dest", -1, 32'(bus.bank_dest), 32'd9);
    check("reset_bank_branch", -1, 32'(bus.bank_branch), 32'd1);
    check("reset_stall", -1, 32'(bus.stall), 32'd0);
    check("reset_in_kernel", -1, 32'(bus.in_kernel), 32'd0);
    check("reset_alu_override", -1, 32'(bus.alu_override), 32'd0);
    check("reset_acks", -1, 32'({bus.irq_ack, bus.swi_ack}), 32'd0);
    check("reset_vector_addr", -1, bus.vector_addr, 32'd0);
    check("reset_special_register", -1, 32'(bus.special_register), 32'd0);
    @(posedge fast_clock); #1;
    reset = 1'b0;

    // 1: IRQ1 and IRQ2 pending, IRQ1 wins (cause 2, vector 6)
    bus.irq_req = 4'b0110;
    tick(1'b1, 1'b0, 3'd2, 4'd7, 1'b0, exp_pass(3'd2, 4'd7, 1'b0, 1'b0));
    enter_seq(4'b0010, 1'b0, 32'd6);
    tick(1'b1, 1'b0, 3'd3, 4'd4, 1'b0, exp_pass(3'd3, 4'd4, 1'b0, 1'b1));
    bus.irq_req = 4'b0000;
    exit_seq();
    tick(1'b1, 1'b0, 3'd1, 4'd2, 1'b0, exp_pass(3'd1, 4'd2, 1'b0, 1'b0));

    // 2: SWI beats IRQ0; IRQ0 enters at the first user boundary after EXIT
    bus.swi_req = 1'b1;
    bus.irq_req = 4'b0001;
    tick(1'b1, 1'b0, 3'd1, 4'd5, 1'b0, exp_pass(3'd1, 4'd5, 1'b0, 1'b0));
    enter_seq(4'b0000, 1'b1, 32'd2);
    bus.swi_req = 1'b0;
    tick(1'b1, 1'b0, 3'd1, 4'd6, 1'b0, exp_pass(3'd1, 4'd6, 1'b0, 1'b1));
    exit_seq();
    tick(1'b1, 1'b0, 3'd1, 4'd7, 1'b0, exp_pass(3'd1, 4'd7, 1'b0, 1'b0));
    enter_seq(4'b0001, 1'b0, 32'd4);
    bus.irq_req = 4'b0000;

    // 3: IRQ3 raised in KERNEL is held off until after EXIT
    bus.irq_req = 4'b1000;
    tick(1'b1, 1'b0, 3'd3, 4'd8, 1'b0, exp_pass(3'd3, 4'd8, 1'b0, 1'b1));
    tick(1'b0, 1'b1, 3'd3, 4'd1, 1'b1, exp_pass(3'd3, 4'd1, 1'b1, 1'b1));
    tick(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, exp_pass(3'd0, 4'd0, 1'b0, 1'b1));
    exit_seq();
    tick(1'b1, 1'b0, 3'd1, 4'd11, 1'b0, exp_pass(3'd1, 4'd11, 1'b0, 1'b0));
    enter_seq(4'b1000, 1'b0, 32'd10);
    bus.irq_req = 4'b0000;
    exit_seq();

    // 4: IRQ2 dropped and everything masked after the latch: still one entry
    bus.irq_req = 4'b0100;
    tick(1'b1, 1'b0, 3'd2, 4'd5, 1'b1, exp_pass(3'd2, 4'd5, 1'b1, 1'b0));
    bus.irq_req  = 4'b0000;
    bus.irq_mask = 4'b1111;
    enter_seq(4'b0100, 1'b0, 32'd8);
    bus.irq_mask = 4'b0000;
    exit_seq();
    tick(1'b1, 1'b0, 3'd2, 4'd6, 1'b0, exp_pass(3'd2, 4'd6, 1'b0, 1'b0));
    tick(1'b1, 1'b0, 3'd3, 4'd6, 1'b0, exp_pass(3'd3, 4'd6, 1'b0, 1'b0));

    // 5: reset while in VECTOR returns straight to USER
    bus.irq_req = 4'b0001;
    tick(1'b1, 1'b0, 3'd2, 4'd2, 1'b0, exp_pass(3'd2, 4'd2, 1'b0, 1'b0));
    tick(1'b0, 1'b0, 3'd2, 4'd3, 1'b0, exp_enter(4'b0001, 1'b0));
`ifdef PRIV_CAUSE_EN
    tick(1'b0, 1'b0, 3'd2, 4'd3, 1'b0, exp_cause());
`endif
    check("vector_stall_before_reset", -1, 32'(bus.stall), 32'd1);
    check("vector_alu_before_reset", -1, 32'(bus.alu_override), 32'd1);
    reset = 1'b1;
    @(posedge fast_clock); #1;
    reset = 1'b0;
    check("post_reset_stall", -1, 32'(bus.stall), 32'd0);
    check("post_reset_in_kernel", -1, 32'(bus.in_kernel), 32'd0);
    check("post_reset_alu_override", -1, 32'(bus.alu_override), 32'd0);
    check("post_reset_acks", -1, 32'({bus.irq_ack, bus.swi_ack}), 32'd0);
    bus.irq_req = 4'b0000;
    tick(1'b1, 1'b0, 3'd4, 4'd9, 1'b1, exp_pass(3'd4, 4'd9, 1'b1, 1'b0));

    // 6: all lines masked for 20 boundaries: pure pass-through
    bus.irq_req  = 4'b1111;
    bus.irq_mask = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 3'(i % 8), 4'(i), 1'(i % 2),
           exp_pass(3'(i % 8), 4'(i), 1'(i % 2), 1'b0));
    end
    bus.irq_req  = 4'b0000;
    bus.irq_mask = 4'b0000;

    repeat (3) @(posedge fast_clock);
    check("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
